weight_stream_mem: RTL and testbench
====================================

# weight_stream_mem

Parametrised, writable weight store for one neuron of the fully connected network. It replaces the fixed, constant-initialised per-neuron weight ROMs. Weights are loaded at run time over a valid/ready port with an auto-incrementing write pointer. On a start pulse the block streams all weights in address order to the MAC datapath, with backpressure and a last-beat flag. It sits between the layer's configuration loader and the neuron's multiply-accumulate unit.

## Interface
Parameters:
- NUM_WEIGHT, default 30: number of weights (neuron fan-in). Must be at least 2.
- DATA_WIDTH, default 16: width of one weight word, signed fixed point, passed through unchanged.
- ADDR_WIDTH, default $clog2(NUM_WEIGHT): pointer width.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- load_valid  in  1  load word present.
- load_data  in  DATA_WIDTH  weight to store.
- load_ready  out  1  block accepts a load word this cycle.
- load_done  out  1  one-cycle pulse after the NUM_WEIGHT-th word is accepted.
- loaded  out  1  a complete weight set is stored.
- start  in  1  request one full streaming pass.
- busy  out  1  a streaming pass is in progress.
- wout  out  DATA_WIDTH  streamed weight.
- wout_valid  out  1  wout holds a valid weight.
- wout_last  out  1  wout is the weight at address NUM_WEIGHT-1.
- wout_ready  in  1  consumer accepts wout this cycle.

## Operation
- Storage: NUM_WEIGHT x DATA_WIDTH array with a synchronous read. Array contents are not reset.
- FSM states are IDLE and STREAM.
- IDLE:
  - load_ready = !start.
  - When a beat is accepted (load_valid & load_ready), write mem[wptr] <= load_data.
  - wptr increments and wraps from NUM_WEIGHT-1 to 0. On that wrap, set loaded=1 and pulse load_done in the next cycle.
  - Any accepted beat while wptr==0 and loaded=1 clears loaded. A partial reload therefore invalidates the stored set.
- start in IDLE:
  - Accepted only when loaded=1 and wptr==0. Otherwise it is ignored and no output toggles.
  - When accepted: go to STREAM, set rptr=0, set busy=1.
- STREAM:
  - load_ready=0.
  - The read pointer advances when the output register is empty or is being drained (wout_valid & wout_ready). Each advance issues a read of mem[rptr], which lands in the output register next cycle with wout_valid=1.
  - wout_last=1 exactly when the held word came from address NUM_WEIGHT-1.
  - After the last address has been issued, no further reads are issued.
  - Leave STREAM and return to IDLE in the cycle the last beat handshakes. busy drops on the next edge.
  - start is ignored while in STREAM.
- Holding: while wout_valid=1 and wout_ready=0, wout and wout_last stay stable.
- Data: weights pass through bit-exact. No sign extension or rounding.

## Timing
- Reset values: load_ready=1 and loaded=0. load_done, busy, wout_valid and wout_last are all 0. wout=0. wptr=0, rptr=0, state is IDLE.
- Reset asserted mid-load or mid-stream aborts immediately and forces all of the reset values above. Array contents are retained but not trusted, because loaded=0.
- Load throughput is one word per cycle. load_done is asserted in the cycle after the final beat is accepted.
- Start latency: start is sampled in cycle T. The first wout_valid=1 appears in T+2 (state change at T+1, read data at T+2), carrying mem[0].
- With wout_ready held at 1, there is one beat per cycle. wout_last is asserted in cycle T+1+NUM_WEIGHT, and busy=0 in T+2+NUM_WEIGHT.
- After any stall, the word at the next address appears one cycle after the stalled beat handshakes, with no gaps beyond that.
- start in the same cycle as the final load beat: the start is ignored, because loaded is still 0 in that cycle.
- start and load_valid in the same IDLE cycle with a valid set stored: start wins, and the load beat is not accepted (load_ready=0).

## Test plan
- Reset then load: after reset, check every output at its reset value. Load 30 words 0x0100..0x011D back-to-back. Expect load_done to pulse for one cycle in the cycle after beat 30, and loaded=1 from then on.
- Full-speed stream: with wout_ready=1, pulse start. Expect wout=0x0100 two cycles later, then 30 consecutive beats, wout_last=1 only on 0x011D, and busy low one cycle after that beat.
- Backpressure: hold wout_ready=0 for 5 cycles on beat 7 (0x0107). Expect wout to stay stable for those 5 cycles, then 0x0108 in the cycle after release, and all 30 words delivered with none lost or duplicated.
- Guarding: pulse start after only 12 words of a reload. Expect start to be ignored with busy=0 and loaded=0. Pulse start during STREAM: expect no restart and load_ready=0 throughout the pass.
- Reset mid-stream: assert rst at beat 15. Expect wout_valid=0, busy=0 and loaded=0 immediately. Reload and stream again, and expect 30 correct beats.
- Collision: with a valid set stored, assert start and load_valid together. Expect a stream to begin, no write to occur, and the stored data to remain unchanged.

Source files
------------

// File: rtl/weight_stream_mem.sv
// weight_stream_mem
// Writable per-neuron weight store. Weights are loaded over a valid/ready port
// with an auto-incrementing write pointer. A start pulse streams the full set in
// address order to the MAC datapath, with backpressure and a last-beat flag.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load_valid      load word present
//   load_data       weight to store
//   load_ready      load word accepted this cycle (IDLE and no start)
//   load_done       one-cycle pulse after the final word of a set is accepted
//   loaded          a complete weight set is stored
//   start           request one full streaming pass
//   busy            streaming pass in progress
//   wout            streamed weight (output register)
//   wout_valid      wout holds a valid weight
//   wout_last       wout came from address NUM_WEIGHT-1
//   wout_ready      consumer accepts wout this cycle
module weight_stream_mem #(
  parameter int NUM_WEIGHT = 30,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = $clog2(NUM_WEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_valid,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
  output logic                  load_done,
  output logic                  loaded,
  input  logic                  start,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] wout,
  output logic                  wout_valid,
  output logic                  wout_last,
  input  logic                  wout_ready
);

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WEIGHT - 1);

  logic [DATA_WIDTH-1:0] mem [NUM_WEIGHT];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
  logic                  loaded_q, loaded_d;
  logic                  load_done_q, load_done_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] wout_q, wout_d;
  logic                  wout_valid_q, wout_valid_d;
  logic                  wout_last_q, wout_last_d;
  logic                  issued_all_q, issued_all_d;

  logic load_fire;
  logic start_go;
  logic drain;
  logic issue;

  // start has priority over a simultaneous load beat.
  assign load_ready = (state_q == IDLE) && !start;
  assign load_fire  = load_valid && load_ready;
  // A pass may only begin from a complete, unmodified set.
  assign start_go   = (state_q == IDLE) && start && loaded_q && (wptr_q == '0);
  assign drain      = wout_valid_q && wout_ready;
  // Read into the output register whenever it is empty or being emptied.
  assign issue      = (state_q == STREAM) && !issued_all_q && (!wout_valid_q || wout_ready);

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    loaded_d     = loaded_q;
    load_done_d  = 1'b0;
    busy_d       = busy_q;
    wout_d       = wout_q;
    wout_valid_d = wout_valid_q;
    wout_last_d  = wout_last_q;
    issued_all_d = issued_all_q;

    case (state_q)
      IDLE: begin
        if (start_go) begin
          state_d      = STREAM;
          rptr_d       = '0;
          busy_d       = 1'b1;
          issued_all_d = 1'b0;
        end else if (load_fire) begin
          if (wptr_q == LAST_ADDR) begin
            wptr_d      = '0;
            loaded_d    = 1'b1;
            load_done_d = 1'b1;
          end else begin
            wptr_d = wptr_q + 1'b1;
            // First word of a reload invalidates the stored set.
            if (wptr_q == '0) loaded_d = 1'b0;
          end
        end
      end

      STREAM: begin
        if (issue) begin
          wout_d       = mem[rptr_q];
          wout_valid_d = 1'b1;
          wout_last_d  = (rptr_q == LAST_ADDR);
          if (rptr_q == LAST_ADDR) issued_all_d = 1'b1;
          else                     rptr_d       = rptr_q + 1'b1;
        end else if (drain) begin
          wout_valid_d = 1'b0;
          wout_last_d  = 1'b0;
        end
        if (drain && wout_last_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      loaded_q     <= 1'b0;
      load_done_q  <= 1'b0;
      busy_q       <= 1'b0;
      wout_q       <= '0;
      wout_valid_q <= 1'b0;
      wout_last_q  <= 1'b0;
      issued_all_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      loaded_q     <= loaded_d;
      load_done_q  <= load_done_d;
      busy_q       <= busy_d;
      wout_q       <= wout_d;
      wout_valid_q <= wout_valid_d;
      wout_last_q  <= wout_last_d;
      issued_all_q <= issued_all_d;
    end
  end

  // Weight array is deliberately not reset; loaded qualifies its contents.
  always_ff @(posedge clk) begin
    if (load_fire) mem[wptr_q] <= load_data;
  end

  assign load_done  = load_done_q;
  assign loaded     = loaded_q;
  assign busy       = busy_q;
  assign wout       = wout_q;
  assign wout_valid = wout_valid_q;
  assign wout_last  = wout_last_q;

endmodule

// File: tb/tb_weight_stream_mem.sv
module tb_weight_stream_mem;
  localparam int NW = 30;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_ready;
  logic          load_done;
  logic          loaded;
  logic          start;
  logic          busy;
  logic [DW-1:0] wout;
  logic          wout_valid;
  logic          wout_last;
  logic          wout_ready;

  weight_stream_mem #(.NUM_WEIGHT(NW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_done  (load_done),
    .loaded     (loaded),
    .start      (start),
    .busy       (busy),
    .wout       (wout),
    .wout_valid (wout_valid),
    .wout_last  (wout_last),
    .wout_ready (wout_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  beat_t         exp_b;
  logic [DW-1:0] model_mem [NW];
  int            model_wptr = 0;
  logic          model_loaded = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;
  int            beats_seen = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every handshaken beat is popped and compared.
  always @(negedge clk) begin
    if (rst === 1'b0 && wout_valid === 1'b1 && wout_ready === 1'b1) begin
      beats_seen++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL stream_beat: got wout=%h last=%b, no beat expected", wout, wout_last);
      end else begin
        exp_b = exp_q.pop_front();
        if (wout !== exp_b.data || wout_last !== exp_b.last) begin
          miscompares++;
          $display("FAIL stream_beat: got wout=%h last=%b, expected wout=%h last=%b",
                   wout, wout_last, exp_b.data, exp_b.last);
        end
      end
    end
  end

  task automatic push_pass();
    for (int i = 0; i < NW; i++)
      exp_q.push_back(beat_t'{data: model_mem[i], last: (i == NW - 1)});
  endtask

  task automatic load_words(input int n, input logic [DW-1:0] base);
    logic wrap;
    wrap = 1'b0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = base + DW'(i);
      #1;
      vectors++;
      if (load_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL load_ready: got %b, expected 1 on beat %0d", load_ready, i);
      end
      if (model_loaded && model_wptr == 0) model_loaded = 1'b0;
      model_mem[model_wptr] = load_data;
      wrap = (model_wptr == NW - 1);
      model_wptr = wrap ? 0 : model_wptr + 1;
      if (wrap) model_loaded = 1'b1;
      tick();
      vectors++;
      if (load_done !== wrap || loaded !== model_loaded) begin
        miscompares++;
        $display("FAIL load_status: got load_done=%b loaded=%b, expected %b %b after beat %0d",
                 load_done, loaded, wrap, model_loaded, i);
      end
    end
    load_valid = 1'b0;
    tick();
    vectors++;
    if (load_done !== 1'b0 || loaded !== model_loaded) begin
      miscompares++;
      $display("FAIL load_tail: got load_done=%b loaded=%b, expected 0 %b",
               load_done, loaded, model_loaded);
    end
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy === 1'b1 && n < limit) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
  endtask

  task automatic check_pass_complete(input string name);
    vectors++;
    if (beats_seen != NW || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_count: got %0d beats (%0d left), expected %0d beats (0 left)",
               name, beats_seen, exp_q.size(), NW);
    end
  endtask

  // Cycle-exact full-speed pass; optionally re-pulses start mid-stream.
  task automatic check_full_pass(input bit poke_start);
    logic eb, ev, el, elr;
    beats_seen = 0;
    wout_ready = 1'b1;
    push_pass();
    start = 1'b1;
    tick();
    for (int c = 1; c <= NW + 2; c++) begin
      start = (poke_start && c == 6);
      #1;
      eb  = (c <= NW + 1);
      ev  = (c >= 2 && c <= NW + 1);
      el  = (c == NW + 1);
      elr = !(c <= NW + 1);
      vectors++;
      if ({busy, wout_valid, wout_last, load_ready} !== {eb, ev, el, elr}) begin
        miscompares++;
        $display("FAIL pass_ctrl: cycle T+%0d got busy/valid/last/lready=%b%b%b%b, expected %b%b%b%b",
                 c, busy, wout_valid, wout_last, load_ready, eb, ev, el, elr);
      end
      if (ev) begin
        vectors++;
        if (wout !== model_mem[c-2]) begin
          miscompares++;
          $display("FAIL pass_data: cycle T+%0d got %h, expected %h", c, wout, model_mem[c-2]);
        end
      end
      if (c < NW + 2) tick();
    end
    start = 1'b0;
    tick();
    vectors++;
    if (busy !== 1'b0 || wout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL pass_norestart: got busy=%b valid=%b, expected 0 0", busy, wout_valid);
    end
    check_pass_complete("pass");
  endtask

  task automatic test_reset();
    rst = 1'b1; load_valid = 1'b0; load_data = '0; start = 1'b0; wout_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if ({load_ready, loaded, load_done, busy, wout_valid, wout_last} !== 6'b100000) begin
      miscompares++;
      $display("FAIL reset_flags: got lready/loaded/done/busy/valid/last=%b%b%b%b%b%b, expected 100000",
               load_ready, loaded, load_done, busy, wout_valid, wout_last);
    end
    vectors++;
    if (wout !== '0) begin
      miscompares++;
      $display("FAIL reset_wout: got %h, expected 0000", wout);
    end
    rst = 1'b0;
    model_wptr = 0;
    model_loaded = 1'b0;
    tick();
  endtask

  task automatic test_load();
    load_words(NW, 16'h0100);
  endtask

  task automatic test_full_speed();
    check_full_pass(1'b0);
  endtask

  task automatic test_backpressure();
    beats_seen = 0;
    wout_ready = 1'b1;
    push_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    repeat (7) tick();
    vectors++;
    if (wout !== model_mem[7] || wout_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_word7: got %h valid=%b, expected %h valid=1", wout, wout_valid, model_mem[7]);
    end
    wout_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (wout !== model_mem[7] || wout_valid !== 1'b1 || wout_last !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold: stall cycle %0d got %h valid=%b last=%b, expected %h 1 0",
                 i, wout, wout_valid, wout_last, model_mem[7]);
      end
      tick();
    end
    wout_ready = 1'b1;
    tick();
    vectors++;
    if (wout !== model_mem[8] || wout_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_resume: got %h valid=%b, expected %h valid=1", wout, wout_valid, model_mem[8]);
    end
    wait_idle(100);
    check_pass_complete("bp");
  endtask

  task automatic test_guard();
    load_words(12, 16'h0200);
    start = 1'b1;
    #1;
    vectors++;
    if (load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL guard_lready: got %b, expected 0 while start high", load_ready);
    end
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (busy !== 1'b0 || wout_valid !== 1'b0 || loaded !== 1'b0) begin
        miscompares++;
        $display("FAIL guard_ignore: got busy=%b valid=%b loaded=%b, expected 0 0 0",
                 busy, wout_valid, loaded);
      end
      tick();
    end
    load_words(NW - 12, 16'h020C);
    check_full_pass(1'b1);
  endtask

  task automatic test_reset_mid_stream();
    beats_seen = 0;
    wout_ready = 1'b1;
    push_pass();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (16) tick();
    vectors++;
    if (wout !== model_mem[15] || wout_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_beat15: got %h valid=%b, expected %h valid=1", wout, wout_valid, model_mem[15]);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({wout_valid, busy, loaded, load_done, wout_last, load_ready} !== 6'b000001 || wout !== '0) begin
      miscompares++;
      $display("FAIL rst_abort: got valid/busy/loaded/done/last/lready=%b%b%b%b%b%b wout=%h, expected 000001 0000",
               wout_valid, busy, loaded, load_done, wout_last, load_ready, wout);
    end
    exp_q.delete();
    model_wptr = 0;
    model_loaded = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    load_words(NW, 16'h0300);
    check_full_pass(1'b0);
  endtask

  task automatic test_collision();
    beats_seen = 0;
    wout_ready = 1'b1;
    push_pass();
    start = 1'b1;
    load_valid = 1'b1;
    load_data = 16'hBEEF;
    #1;
    vectors++;
    if (load_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL coll_lready: got %b, expected 0", load_ready);
    end
    tick();
    start = 1'b0;
    load_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || loaded !== 1'b1) begin
      miscompares++;
      $display("FAIL coll_start: got busy=%b loaded=%b, expected 1 1", busy, loaded);
    end
    wait_idle(100);
    check_pass_complete("coll");
    tick();
    check_full_pass(1'b0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_full_speed();
    test_backpressure();
    test_guard();
    test_reset_mid_stream();
    test_collision();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
